token_client_requester: RTL and testbench

- Client-side requester agent for the token-ring arbitration fabric.
- Queues transfer jobs from a local source and drives the 4-phase req/ack handshake toward a ring controller instance.
- Holds ownership for the job's beat count, then releases.
- Sits between local logic and one controller port, replacing the free-running client model.

---
 rtl/token_client_requester_pkg.sv | 34 +++
 rtl/token_client_requester_job_fifo.sv | 49 ++++
 rtl/token_client_requester.sv | 111 +++++++++++
 tb/tb_token_client_requester.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/token_client_requester_pkg.sv
// Shared encodings for the token-ring fabric and the client requester FSM.
`default_nettype none

package token_client_requester_pkg;

  typedef enum logic [1:0] {
    RING_A = 2'd0,
    RING_B = 2'd1,
    RING_C = 2'd2,
    RING_X = 2'd3
  } ring_sel_e;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_READY = 2'd1,
    CTRL_BUSY  = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    CLI_NO_REQ     = 2'd0,
    CLI_REQ        = 2'd1,
    CLI_HAVE_TOKEN = 2'd2
  } client_state_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } req_state_e;

endpackage

`default_nettype wire

// File: rtl/token_client_requester_job_fifo.sv
// DEPTH x W synchronous FIFO holding pending job lengths; head is visible on dout.
`default_nettype none

module token_client_requester_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/token_client_requester.sv
// Client requester: queues jobs and runs the 4-phase req/ack handshake for each one.
`default_nettype none

module token_client_requester
  import token_client_requester_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int DEPTH = 4,
  parameter int TMO   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             ack,
  output logic             beat_valid,
  output logic             beat_last,
  output logic             done,
  output logic             busy,
  output logic             timeout_err,
  output logic             proto_err
);
  localparam int TW = $clog2(TMO + 1);

  req_state_e       state;
  logic [LEN_W-1:0] beat_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [LEN_W-1:0] head_len;
  logic             full;
  logic             empty;
  logic             pop;

  assign pop        = (state == S_IDLE) && !empty;
  assign job_ready  = !full;
  assign beat_valid = (state == S_HOLD);
  assign beat_last  = beat_valid && (beat_cnt == LEN_W'(1));
  assign busy       = (state != S_IDLE) || !empty;

  token_client_requester_job_fifo #(
    .DEPTH (DEPTH),
    .W     (LEN_W)
  ) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (job_valid),
    .din   (job_len),
    .pop   (pop),
    .dout  (head_len),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req         <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      beat_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A zero-length head is popped and dropped without a handshake.
          if (!empty && head_len != '0) begin
            beat_cnt <= head_len;
            tmo_cnt  <= '0;
            req      <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack) begin
            state <= S_HOLD;
          end else if (tmo_cnt != TW'(TMO)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt == TW'(TMO - 1)) timeout_err <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!ack) begin
            proto_err <= 1'b1;
            req       <= 1'b0;
            beat_cnt  <= '0;
            state     <= S_RELEASE;
          end else if (beat_cnt == LEN_W'(1)) begin
            req      <= 1'b0;
            beat_cnt <= '0;
            state    <= S_RELEASE;
          end else begin
            beat_cnt <= beat_cnt - LEN_W'(1);
          end
        end
        S_RELEASE: begin
          if (!ack) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_token_client_requester.sv
// Directed self-checking bench for token_client_requester.
`default_nettype none

module tb_token_client_requester;
  logic       clk;
  logic       rst;
  logic       job_valid;
  logic [3:0] job_len;
  logic       job_ready;
  logic       req;
  logic       ack;
  logic       beat_valid;
  logic       beat_last;
  logic       done;
  logic       busy;
  logic       timeout_err;
  logic       proto_err;

  int vectors;
  int miscompares;

  int mon_beats;
  int mon_done;
  int mon_req_rise;
  int cur_beats;
  logic req_q;
  int done_lens[$];

  logic auto_ack;
  int   ack_delay;
  int   rcnt;

  token_client_requester #(.LEN_W(4), .DEPTH(4), .TMO(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_len     (job_len),
    .job_ready   (job_ready),
    .req         (req),
    .ack         (ack),
    .beat_valid  (beat_valid),
    .beat_last   (beat_last),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (beat_valid) begin
      mon_beats++;
      cur_beats++;
    end
    if (done) begin
      mon_done++;
      done_lens.push_back(cur_beats);
      cur_beats = 0;
    end
    if (req && !req_q) mon_req_rise++;
    req_q = req;
  end

  // Simple ring-controller model: grant ack_delay cycles after req, drop after req falls.
  initial begin
    rcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (auto_ack) begin
        if (req) begin
          if (rcnt >= ack_delay) ack = 1'b1;
          rcnt++;
        end else begin
          ack  = 1'b0;
          rcnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_beats    = 0;
    mon_done     = 0;
    mon_req_rise = 0;
    cur_beats    = 0;
    done_lens.delete();
  endtask

  task automatic do_reset();
    auto_ack  = 1'b0;
    ack       = 1'b0;
    job_valid = 1'b0;
    job_len   = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_done(input int n, input string name);
    int g;
    g = 0;
    while (mon_done < n && g < 500) begin
      tick();
      g++;
    end
    vectors++;
    if (mon_done < n) begin
      miscompares++;
      $display("FAIL %s_wait_done: got %0d done pulses, expected %0d", name, mon_done, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (req !== 1'b0)         begin miscompares++; $display("FAIL rst_req: got %b expected 0", req); end
    vectors++; if (done !== 1'b0)        begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
    vectors++; if (beat_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_beat_valid: got %b expected 0", beat_valid); end
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (job_ready !== 1'b1)   begin miscompares++; $display("FAIL rst_job_ready: got %b expected 1", job_ready); end
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    vectors++; if (proto_err !== 1'b0)   begin miscompares++; $display("FAIL rst_proto_err: got %b expected 0", proto_err); end
  endtask

  task automatic test_single_job();
    do_reset();
    job_len = 4'd3; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    vectors++; if (req !== 1'b0)  begin miscompares++; $display("FAIL single_req_at_accept: got %b expected 0", req); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_queued: got %b expected 1", busy); end
    tick();
    vectors++; if (req !== 1'b1)  begin miscompares++; $display("FAIL single_req_rise: got %b expected 1", req); end
    tick();
    ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++; if (beat_valid !== 1'b1) begin miscompares++; $display("FAIL single_beat%0d_valid: got %b expected 1", i, beat_valid); end
      vectors++; if (beat_last !== (i == 3)) begin miscompares++; $display("FAIL single_beat%0d_last: got %b expected %b", i, beat_last, (i == 3)); end
      vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL single_beat%0d_req: got %b expected 1", i, req); end
    end
    tick();
    vectors++; if (req !== 1'b0)        begin miscompares++; $display("FAIL single_req_release: got %b expected 0", req); end
    vectors++; if (beat_valid !== 1'b0) begin miscompares++; $display("FAIL single_beat_after: got %b expected 0", beat_valid); end
    vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL single_done_early: got %b expected 0", done); end
    ack = 1'b0;
    tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL single_done_pulse: got %b expected 1", done); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_width: got %b expected 0", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    vectors++; if (mon_beats !== 3) begin miscompares++; $display("FAIL single_beat_count: got %0d expected 3", mon_beats); end
  endtask

  task automatic test_queue_full();
    int g;
    do_reset();
    ack_delay = 0;
    auto_ack  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      job_len   = 4'(i);
      job_valid = 1'b1;
      g = 0;
      while (!job_ready && g < 200) begin
        tick();
        g++;
      end
      tick();
    end
    vectors++; if (job_ready !== 1'b0) begin miscompares++; $display("FAIL full_job_ready: got %b expected 0", job_ready); end
    job_valid = 1'b0;
    wait_done(5, "full");
    repeat (3) tick();
    vectors++; if (mon_done !== 5) begin miscompares++; $display("FAIL full_done_count: got %0d expected 5", mon_done); end
    vectors++; if (done_lens.size() !== 5) begin miscompares++; $display("FAIL full_job_count: got %0d expected 5", done_lens.size()); end
    for (int i = 0; i < 5 && i < done_lens.size(); i++) begin
      vectors++;
      if (done_lens[i] !== i + 1) begin
        miscompares++;
        $display("FAIL full_order_job%0d: got %0d beats expected %0d", i, done_lens[i], i + 1);
      end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_zero_len();
    do_reset();
    ack_delay = 1;
    auto_ack  = 1'b1;
    job_len = 4'd0; job_valid = 1'b1;
    tick();
    job_len = 4'd2;
    tick();
    job_valid = 1'b0;
    vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL zero_req_for_len0: got %b expected 0", req); end
    wait_done(1, "zero");
    repeat (4) tick();
    vectors++; if (mon_req_rise !== 1) begin miscompares++; $display("FAIL zero_req_rises: got %0d expected 1", mon_req_rise); end
    vectors++; if (mon_done !== 1)     begin miscompares++; $display("FAIL zero_done_count: got %0d expected 1", mon_done); end
    vectors++; if (mon_beats !== 2)    begin miscompares++; $display("FAIL zero_beats: got %0d expected 2", mon_beats); end
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL zero_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    job_len = 4'd1; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tick();
    repeat (63) tick();
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b expected 0", timeout_err); end
    tick();
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_set: got %b expected 1", timeout_err); end
    vectors++; if (req !== 1'b1)         begin miscompares++; $display("FAIL tmo_req_held: got %b expected 1", req); end
    repeat (6) tick();
    vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL tmo_req_still: got %b expected 1", req); end
    ack_delay = 0;
    auto_ack  = 1'b1;
    wait_done(1, "tmo");
    tick();
    vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b expected 1", timeout_err); end
    vectors++; if (mon_beats !== 1)      begin miscompares++; $display("FAIL tmo_beats: got %0d expected 1", mon_beats); end
    vectors++; if (proto_err !== 1'b0)   begin miscompares++; $display("FAIL tmo_proto_err: got %b expected 0", proto_err); end
  endtask

  task automatic test_proto_err();
    do_reset();
    vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL proto_tmo_cleared: got %b expected 0", timeout_err); end
    job_len = 4'd4; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    tick();
    vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL proto_req: got %b expected 1", req); end
    ack = 1'b1;
    tick();
    tick();
    vectors++; if (beat_valid !== 1'b1) begin miscompares++; $display("FAIL proto_beat2: got %b expected 1", beat_valid); end
    ack = 1'b0;
    tick();
    vectors++; if (proto_err !== 1'b1)  begin miscompares++; $display("FAIL proto_err_set: got %b expected 1", proto_err); end
    vectors++; if (req !== 1'b0)        begin miscompares++; $display("FAIL proto_req_drop: got %b expected 0", req); end
    vectors++; if (beat_valid !== 1'b0) begin miscompares++; $display("FAIL proto_abort: got %b expected 0", beat_valid); end
    tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL proto_done: got %b expected 1", done); end
    tick();
    vectors++; if (mon_beats !== 2)    begin miscompares++; $display("FAIL proto_beats: got %0d expected 2", mon_beats); end
    vectors++; if (proto_err !== 1'b1) begin miscompares++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
  endtask

  task automatic test_reset_mid_hold();
    int g;
    do_reset();
    ack_delay = 0;
    auto_ack  = 1'b1;
    job_valid = 1'b1;
    job_len = 4'd5; tick();
    job_len = 4'd1; tick();
    job_len = 4'd2; tick();
    job_valid = 1'b0;
    g = 0;
    while (!beat_valid && g < 50) begin
      tick();
      g++;
    end
    tick();
    vectors++; if (beat_valid !== 1'b1) begin miscompares++; $display("FAIL rsthold_in_beat2: got %b expected 1", beat_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++; if (req !== 1'b0)        begin miscompares++; $display("FAIL rsthold_req: got %b expected 0", req); end
    vectors++; if (beat_valid !== 1'b0) begin miscompares++; $display("FAIL rsthold_beat_valid: got %b expected 0", beat_valid); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL rsthold_busy: got %b expected 0", busy); end
    vectors++; if (job_ready !== 1'b1)  begin miscompares++; $display("FAIL rsthold_queue_empty: got %b expected 1", job_ready); end
    clear_mon();
    repeat (4) tick();
    vectors++; if (mon_done !== 0) begin miscompares++; $display("FAIL rsthold_no_done: got %0d expected 0", mon_done); end
    job_len = 4'd2; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    wait_done(1, "rsthold");
    tick();
    vectors++; if (mon_beats !== 2) begin miscompares++; $display("FAIL rsthold_new_job_beats: got %0d expected 2", mon_beats); end
    vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL rsthold_busy_end: got %b expected 0", busy); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    req_q       = 1'b0;
    auto_ack    = 1'b0;
    ack_delay   = 0;
    ack         = 1'b0;
    rst         = 1'b1;
    job_valid   = 1'b0;
    job_len     = '0;
    clear_mon();
    test_reset();
    test_single_job();
    test_queue_full();
    test_zero_len();
    test_timeout();
    test_proto_err();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
